ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 20 ++
 rtl/ram_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared bus widths, state encodings and types for the two-master RAM arbiter.
`ifndef RAM_ARBITER_DEFINES
`define RAM_ARBITER_DEFINES
`define RegBus      31:0
`define DataAddrBus 31:0
`define ArbIdle     2'b00
`define ArbBusy     2'b01
`define ArbDone     2'b10
`endif

package ram_arbiter_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = `ArbIdle,
    ARB_BUSY = `ArbBusy,
    ARB_DONE = `ArbDone
  } arb_state_e;

  // One master's access request, captured when it wins arbitration.
  typedef struct packed {
    logic                we;
    logic [`DataAddrBus] addr;
    logic [3:0]          sel;
    logic [`RegBus]      wdata;
  } req_latch_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way winner selection: a lone requester wins; ties go to the master that
// did not own the RAM last, or always to master 0 in fixed-priority mode.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       fixed_pri,
  output logic       winner
);

  // Pick the winning master index from the current request pattern.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b10) begin
      winner = 1'b1;
    end else if (req == 2'b11) begin
      winner = fixed_pri ? 1'b0 : ~last_owner;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two bus masters onto one single-port RAM. Each access takes three
// cycles: IDLE (arbitrate and latch), BUSY (drive the RAM), DONE (ack).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [`DataAddrBus] m0_addr,
  input  logic [3:0]          m0_sel,
  input  logic [`RegBus]      m0_wdata,
  output logic                m0_gnt,
  output logic                m0_ack,
  output logic [`RegBus]      m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [`DataAddrBus] m1_addr,
  input  logic [3:0]          m1_sel,
  input  logic [`RegBus]      m1_wdata,
  output logic                m1_gnt,
  output logic                m1_ack,
  output logic [`RegBus]      m1_rdata,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [`DataAddrBus] ram_addr,
  output logic [3:0]          ram_sel,
  output logic [`RegBus]      ram_data_o,
  input  logic [`RegBus]      ram_data_i
);

  arb_state_e     state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_owner_q, last_owner_d;
  req_latch_t     latch_q, latch_d;
  logic [`RegBus] rdata_q, rdata_d;

  logic           winner;
  logic           busy;
  logic           done;
  req_latch_t     m0_req_bus, m1_req_bus;

  logic [NUM_MASTERS-1:0] gnt_vec;
  logic [NUM_MASTERS-1:0] ack_vec;
  logic [`RegBus]         rdata_vec [NUM_MASTERS];

  assign m0_req_bus = '{we: m0_we, addr: m0_addr, sel: m0_sel, wdata: m0_wdata};
  assign m1_req_bus = '{we: m1_we, addr: m1_addr, sel: m1_sel, wdata: m1_wdata};

  rr_arb2 u_rr_arb2 (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner_q),
    .fixed_pri  (FIXED_PRIORITY != 0),
    .winner     (winner)
  );

  // State, ownership, request latch and read-data registers; reset aborts any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      latch_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      latch_q      <= latch_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state: latch the winner in IDLE, capture read data leaving BUSY,
  // remember the owner for round-robin leaving DONE.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    latch_d      = latch_q;
    rdata_d      = rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = winner;
          latch_d = winner ? m1_req_bus : m0_req_bus;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        rdata_d = latch_q.we ? '0 : ram_data_i;
        state_d = ARB_DONE;
      end
      ARB_DONE: begin
        last_owner_d = owner_q;
        state_d      = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign busy = (state_q == ARB_BUSY);
  assign done = (state_q == ARB_DONE);

  // RAM port is only active during BUSY; otherwise everything is held at zero.
  assign ram_ce     = busy;
  assign ram_we     = busy & latch_q.we;
  assign ram_addr   = busy ? latch_q.addr  : '0;
  assign ram_sel    = busy ? latch_q.sel   : '0;
  assign ram_data_o = busy ? latch_q.wdata : '0;

  // Per-master grant, ack and read-data; only the owner ever sees non-zero values.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign gnt_vec[gi]   = (busy | done) & (owner_q == 1'(gi));
      assign ack_vec[gi]   = done & (owner_q == 1'(gi));
      assign rdata_vec[gi] = ack_vec[gi] ? rdata_q : '0;
    end
  endgenerate

  assign m0_gnt   = gnt_vec[0];
  assign m1_gnt   = gnt_vec[1];
  assign m0_ack   = ack_vec[0];
  assign m1_ack   = ack_vec[1];
  assign m0_rdata = rdata_vec[0];
  assign m1_rdata = rdata_vec[1];

endmodule
